// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply, restoring divide, HI/LO registers.
// Build option MDU_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] mf_data,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [2*W-1:0]       mcand_q, mcand_d;
    logic [W-1:0]         opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 zero_div_q, zero_div_d;
    logic [W-1:0]         hi_q, hi_d;
    logic [W-1:0]         lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_by_zero_q, div_by_zero_d;

    logic                 accept;
    logic                 signed_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         b_mag;
    logic                 last_iter;
    logic [W:0]           shifted;
    logic [W:0]           trial;
    logic [2*W-1:0]       prod_fix;
    logic [W-1:0]         quo_fix;
    logic [W-1:0]         rem_fix;

    assign busy        = (state_q != S_IDLE);
    assign stall       = op_valid & busy;
    assign accept      = op_valid & ~busy & ~flush;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Signed ops iterate on magnitudes; the sign is reapplied in FIX.
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & rs_data[W-1];
    assign b_neg     = signed_op & rt_data[W-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;

    // Restoring divide step: acc holds {remainder, dividend/quotient}.
    assign shifted = {acc_q[2*W-1:W], acc_q[W-1]};
    assign trial   = shifted - {1'b0, opb_q};

    assign prod_fix = res_neg_q ? -acc_q : acc_q;
    assign quo_fix  = zero_div_q ? {W{1'b1}} : (res_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
    assign rem_fix  = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

`ifdef MDU_EARLY_OUT_EN
    assign last_iter = (cnt_q == CNT_WIDTH'(W-1)) || (!is_div_q && opb_q[W-1:1] == '0);
`else
    assign last_iter = (cnt_q == CNT_WIDTH'(W-1));
`endif

    always_comb begin
        mf_data = '0;
        if (op == OP_MFHI) begin
            mf_data = hi_q;
        end else if (op == OP_MFLO) begin
            mf_data = lo_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        opb_d         = opb_q;
        is_div_d      = is_div_q;
        res_neg_d     = res_neg_q;
        rem_neg_d     = rem_neg_q;
        zero_div_d    = zero_div_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d    = S_RUN;
                            cnt_d      = '0;
                            acc_d      = '0;
                            mcand_d    = {{W{1'b0}}, a_mag};
                            opb_d      = b_mag;
                            is_div_d   = 1'b0;
                            res_neg_d  = a_neg ^ b_neg;
                            rem_neg_d  = 1'b0;
                            zero_div_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d    = S_RUN;
                            cnt_d      = '0;
                            acc_d      = {{W{1'b0}}, a_mag};
                            opb_d      = b_mag;
                            is_div_d   = 1'b1;
                            res_neg_d  = a_neg ^ b_neg;
                            rem_neg_d  = a_neg;
                            zero_div_d = (rt_data == '0);
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (is_div_q) begin
                    if (!trial[W]) begin
                        acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
                    end
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end
                if (last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d          = rem_fix;
                    lo_d          = quo_fix;
                    div_by_zero_d = zero_div_q;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A squashed op leaves HI/LO untouched and never reports completion.
        if (flush && busy) begin
            state_d       = S_IDLE;
            hi_d          = hi_q;
            lo_d          = lo_q;
            done_d        = 1'b0;
            div_by_zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            opb_q         <= '0;
            is_div_q      <= 1'b0;
            res_neg_q     <= 1'b0;
            rem_neg_q     <= 1'b0;
            zero_div_q    <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            opb_q         <= opb_d;
            is_div_q      <= is_div_d;
            res_neg_q     <= res_neg_d;
            rem_neg_q     <= rem_neg_d;
            zero_div_q    <= zero_div_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level reference model checked every cycle, directed literal cases, random ops.
`timescale 1ns/1ps
module tb_mult_div_unit;
    localparam int DW = 32;

`ifdef MDU_EARLY_OUT_EN
    localparam int MULT73_LAT  = 3;
    localparam int MULTU53_LAT = 3;
`else
    localparam int MULT73_LAT  = 33;
    localparam int MULTU53_LAT = 33;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [2:0]    op;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          flush;
    logic          stall;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [DW-1:0] mf_data;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural result of a mul/div, straight from integer arithmetic.
    task automatic computeResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz);
        longint sa, sb, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rdbz = 1'b0;
        up = '0;
        case (o)
            3'd0: up = sa * sb;
            3'd1: up = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) begin
                    rdbz = 1'b1;
                    up = {a, 32'hFFFFFFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    up = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 0) begin
                    rdbz = 1'b1;
                    up = {a, 32'hFFFFFFFF};
                end else begin
                    up = {a % b, a / b};
                end
            end
        endcase
        rhi = up[63:32];
        rlo = up[31:0];
    endtask

    // Edges from acceptance to the edge that delivers the result.
    function automatic int latencyOf(input logic [2:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        logic [31:0] mag;
        int k;
`endif
        latencyOf = DW + 1;
`ifdef MDU_EARLY_OUT_EN
        if (o == 3'd0 || o == 3'd1) begin
            mag = (o == 3'd0 && b[31]) ? -b : b;
            k = 1;
            for (int i = 0; i < 32; i++) begin
                if (mag[i]) k = i + 1;
            end
            latencyOf = k + 1;
        end
`endif
    endfunction

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dbz, p_dbz;
    int          m_left;
    bit          model_ready = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
                    end
                end
            end else if (op_valid && !flush) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        computeResult(op, rs_data, rt_data, p_hi, p_lo, p_dbz);
                        m_left = latencyOf(op, rt_data);
                    end
                    3'd6: m_hi = rs_data;
                    3'd7: m_lo = rs_data;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("busy", 64'(busy), 64'(m_left > 0));
            checkOutput("stall", 64'(stall), 64'(op_valid && m_left > 0));
            checkOutput("done", 64'(done), 64'(m_done));
            checkOutput("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            checkOutput("hi", 64'(hi), 64'(m_hi));
            checkOutput("lo", 64'(lo), 64'(m_lo));
            if (op_valid && op == 3'd4) checkOutput("mf_data_hi", 64'(mf_data), 64'(m_hi));
            if (op_valid && op == 3'd5) checkOutput("mf_data_lo", 64'(mf_data), 64'(m_lo));
        end
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busyCycles);
        cycles = 0;
        busyCycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            if (busy === 1'b1) busyCycles++;
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("done_reached", 64'(done), 64'd1);
    endtask

    task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz);
        int cycles, busyCycles;
        applyStimulus(o, a, b);
        waitDone(cycles, busyCycles);
        checkOutput({name, "_latency"}, 64'(cycles), 64'(expLat));
        checkOutput({name, "_busy_cycles"}, 64'(busyCycles), 64'(expLat));
        checkOutput({name, "_hi"}, 64'(hi), 64'(expHi));
        checkOutput({name, "_lo"}, 64'(lo), 64'(expLo));
        checkOutput({name, "_dbz"}, 64'(div_by_zero), 64'(expDbz));
        @(posedge clk); #1;
        checkOutput({name, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({name, "_dbz_pulse"}, 64'(div_by_zero), 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: pickOperand = 32'd0;
            1: pickOperand = 32'hFFFFFFFF;
            2: pickOperand = 32'h80000000;
            3: pickOperand = 32'h7FFFFFFF;
            4: pickOperand = 32'($urandom_range(0, 20));
            5: pickOperand = -32'($urandom_range(1, 20));
            default: pickOperand = $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles, stallCycles, sawDone;
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);

        runOp("mult_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, MULT73_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        runOp("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runOp("divu_10_3", 3'd3, 32'd10, 32'd3, 33, 32'd1, 32'd3, 1'b0);
        runOp("divu_by_zero", 3'd3, 32'h0000000A, 32'd0, 33, 32'h0000000A, 32'hFFFFFFFF, 1'b1);
        runOp("div_by_zero_neg", 3'd2, 32'hFFFFFFF9, 32'd0, 33, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        runOp("div_minneg_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 1'b0);
        runOp("multu_5_3", 3'd1, 32'd5, 32'd3, MULTU53_LAT, 32'd0, 32'd15, 1'b0);

        // MFHI held while a MULTU runs
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        op_valid = 1'b1; op = 3'd4; rs_data = '0; rt_data = '0;
        cycles = 0; stallCycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            if (stall === 1'b1) stallCycles++;
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("mfhi_stall_cycles", 64'(stallCycles), 64'd33);
        checkOutput("mfhi_stall_released", 64'(stall), 64'd0);
        checkOutput("mfhi_new_hi", 64'(mf_data), 64'hFFFFFFFE);
        op = 3'd5;
        #1;
        checkOutput("mflo_new_lo", 64'(mf_data), 64'h00000001);
        @(posedge clk); #1;
        op_valid = 1'b0;

        // MTLO then a flushed MULT
        applyStimulus(3'd7, 32'h12345678, 32'd0);
        checkOutput("mtlo_lo", 64'(lo), 64'h12345678);
        checkOutput("mtlo_busy", 64'(busy), 64'd0);
        applyStimulus(3'd0, 32'h00001234, 32'h00ABCDEF);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        sawDone = 0;
        repeat (40) begin
            if (done === 1'b1) sawDone++;
            @(posedge clk); #1;
        end
        checkOutput("flush_no_done", 64'(sawDone), 64'd0);
        checkOutput("flush_hi_kept", 64'(hi), 64'hFFFFFFFE);
        checkOutput("flush_lo_kept", 64'(lo), 64'h12345678);

        // Reset in the middle of a DIV
        applyStimulus(3'd2, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_hi", 64'(hi), 64'd0);
        checkOutput("midreset_lo", 64'(lo), 64'd0);

        for (int n = 0; n < 6000; n++) begin
            op_valid = ($urandom_range(0, 2) != 0);
            op       = 3'($urandom_range(0, 7));
            rs_data  = pickOperand();
            rt_data  = pickOperand();
            flush    = ($urandom_range(0, 59) == 0);
            reset    = ($urandom_range(0, 999) == 0);
            @(posedge clk); #1;
        end
        op_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
